// File: rtl/ws2812_fader_array_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_fader_array_pkg
//   Shared constants for the WS2812 fader array: FSM state encodings, the
//   byte order of one LED on the wire (G, R, B), and the rotation amounts that
//   derive the R and B re-target values from one random word when an LED
//   re-targets as a whole.
// -----------------------------------------------------------------------------
package ws2812_fader_array_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_HOLDOFF = 2'd0;
    localparam logic [1:0] ST_TRIG    = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;

    // Channel order within one LED as it goes out on the wire
    localparam logic [1:0] CH_G = 2'd0;
    localparam logic [1:0] CH_R = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam int BYTES_PER_LED = 3;

    // Rotations applied to the random word for R and B in locked-LED mode
    localparam int ROT_R = 5;
    localparam int ROT_B = 10;

    function automatic logic [15:0] rotl16(input logic [15:0] word, input int n);
        return (word << n) | (word >> (16 - n));
    endfunction

endpackage

// File: rtl/ws2812_fade_step.sv
// -----------------------------------------------------------------------------
// ws2812_fade_step
//   Combinational one-read fade step for a single colour channel: moves the
//   current value toward the target by at most STEP, landing exactly on the
//   target instead of overshooting.
// Ports
//   cur_i      in   COLOR_WIDTH  current channel value
//   tgt_i      in   COLOR_WIDTH  target channel value
//   next_o     out  COLOR_WIDTH  value after this read
//   arrived_o  out  1            current already equals target
// -----------------------------------------------------------------------------
module ws2812_fade_step #(
    parameter int COLOR_WIDTH = 8,
    parameter int STEP        = 1
) (
    input  logic [COLOR_WIDTH-1:0] cur_i,
    input  logic [COLOR_WIDTH-1:0] tgt_i,
    output logic [COLOR_WIDTH-1:0] next_o,
    output logic                   arrived_o
);

    localparam int W         = COLOR_WIDTH;
    localparam int MAX_DELTA = (1 << W) - 1;
    // A STEP wider than the channel range behaves exactly like the full range.
    localparam logic [W-1:0] STEP_N = W'((STEP > MAX_DELTA) ? MAX_DELTA : STEP);

    logic [W:0]   cur_x;
    logic [W:0]   tgt_x;
    logic [W:0]   diff;
    logic [W-1:0] moved;

    always_comb begin
        cur_x = {1'b0, cur_i};
        tgt_x = {1'b0, tgt_i};
        // The subtraction is ordered by the compare, so diff is never negative.
        if (cur_x < tgt_x) begin
            diff  = tgt_x - cur_x;
            moved = cur_i + STEP_N;
        end else begin
            diff  = cur_x - tgt_x;
            moved = cur_i - STEP_N;
        end
        // moved is only taken when it cannot pass the target.
        next_o = (diff > {1'b0, STEP_N}) ? moved : tgt_i;
    end

    assign arrived_o = (cur_i == tgt_i);

endmodule

// File: rtl/ws2812_fader_array.sv
// -----------------------------------------------------------------------------
// ws2812_fader_array
//   Per-LED, per-channel colour fader feeding a WS2812 bit driver. After an
//   idle holdoff it pulses trigger_o, then serves one byte per data_request_i
//   in wire order (LED0 G,R,B, LED1 G,R,B, ...). Every read returns the
//   channel's current value and then steps it toward its random target; a
//   channel (or, with LOCK_LED, a whole LED) that has arrived re-targets.
// Ports
//   clk             in   1   system clock, rising edge
//   rst             in   1   asynchronous active-high reset
//   random_i        in   16  free-running random word, sampled on re-target
//   data_request_i  in   1   driver wants the next byte (honoured in STREAM)
//   trigger_o       out  1   one-clock pulse that starts a frame
//   color_now_o     out  8   byte for the latest request, registered
//   frame_busy_o    out  1   high while the frame is being streamed
// -----------------------------------------------------------------------------
module ws2812_fader_array
    import ws2812_fader_array_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int COLOR_WIDTH  = 8,
    parameter int HOLDOFF_TIME = 1024,
    parameter int STEP         = 1,
    parameter bit LOCK_LED     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] random_i,
    input  logic        data_request_i,
    output logic        trigger_o,
    output logic [7:0]  color_now_o,
    output logic        frame_busy_o
);

    localparam int NUM_BYTES = BYTES_PER_LED * NUM_LEDS;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam int CNT_W     = $clog2(HOLDOFF_TIME + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_TIME - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             chan_q, chan_d;
    logic [7:0]             color_q, color_d;
    logic                   trigger_q;
    logic                   busy_q;
    logic [COLOR_WIDTH-1:0] current_q [NUM_BYTES];
    logic [COLOR_WIDTH-1:0] target_q  [NUM_BYTES];

    logic                   serve;
    logic [COLOR_WIDTH-1:0] cur_sel;
    logic [COLOR_WIDTH-1:0] tgt_sel;
    logic [COLOR_WIDTH-1:0] step_next;
    logic                   step_arrived;
    logic [IDX_W-1:0]       base_idx;
    logic                   led_done;
    logic [7:0]             cur_byte;

    assign serve   = (state_q == ST_STREAM) && data_request_i;
    assign cur_sel = current_q[idx_q];
    assign tgt_sel = target_q[idx_q];

    ws2812_fade_step #(
        .COLOR_WIDTH (COLOR_WIDTH),
        .STEP        (STEP)
    ) u_fade_step (
        .cur_i     (cur_sel),
        .tgt_i     (tgt_sel),
        .next_o    (step_next),
        .arrived_o (step_arrived)
    );

    // First byte (G) of the LED that owns the byte being served.
    assign base_idx = idx_q - IDX_W'(chan_q);

    // Locked mode: the LED re-targets only on its B read with all three settled.
    assign led_done = step_arrived && (chan_q == CH_B)
                   && (current_q[base_idx + IDX_W'(CH_G)] == target_q[base_idx + IDX_W'(CH_G)])
                   && (current_q[base_idx + IDX_W'(CH_R)] == target_q[base_idx + IDX_W'(CH_R)]);

    // Channels narrower than a byte are zero-extended; wider ones keep their MSBs.
    if (COLOR_WIDTH >= 8) begin : g_byte_msb
        assign cur_byte = cur_sel[COLOR_WIDTH-1 -: 8];
    end else begin : g_byte_ext
        assign cur_byte = 8'(cur_sel);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chan_d  = chan_q;
        color_d = color_q;
        case (state_q)
            ST_HOLDOFF: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                cnt_d   = '0;
                idx_d   = '0;
                chan_d  = CH_G;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (data_request_i) begin
                    color_d = cur_byte;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        chan_d  = CH_G;
                        state_d = ST_HOLDOFF;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        chan_d = (chan_q == CH_B) ? CH_G : chan_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_HOLDOFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HOLDOFF;
            cnt_q     <= '0;
            idx_q     <= '0;
            chan_q    <= CH_G;
            color_q   <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            chan_q    <= chan_d;
            color_q   <= color_d;
            trigger_q <= (state_d == ST_TRIG);
            busy_q    <= (state_d == ST_STREAM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the colour store is a flop array, not a RAM, so it takes the async reset like any register.
            for (int i = 0; i < NUM_BYTES; i++) begin
                current_q[i] <= '0;
                target_q[i]  <= '0;
            end
        end else if (serve) begin
            if (!step_arrived) begin
                current_q[idx_q] <= step_next;
            end else if (!LOCK_LED) begin
                target_q[idx_q] <= random_i[COLOR_WIDTH-1:0];
            end
            if (LOCK_LED && led_done) begin
                target_q[base_idx + IDX_W'(CH_G)] <= random_i[COLOR_WIDTH-1:0];
                target_q[base_idx + IDX_W'(CH_R)] <= COLOR_WIDTH'(rotl16(random_i, ROT_R));
                target_q[base_idx + IDX_W'(CH_B)] <= COLOR_WIDTH'(rotl16(random_i, ROT_B));
            end
        end
    end

    assign trigger_o    = trigger_q;
    assign color_now_o  = color_q;
    assign frame_busy_o = busy_q;

endmodule

// File: tb/tb_ws2812_fader_array.sv
// -----------------------------------------------------------------------------
// tb_ws2812_fader_array
//   Drives three fader arrays (STEP=1; STEP=16; STEP=1 with LOCK_LED) with the
//   same stimulus and checks each against a behavioural model of the colour
//   store and frame timing.
// -----------------------------------------------------------------------------
module tb_ws2812_fader_array;

    localparam int NUM_LEDS = 2;
    localparam int FRAME    = 3 * NUM_LEDS;
    localparam int HOLD     = 4;
    localparam int NDUT     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rnd = '0;
    logic        req = 1'b0;
    logic        trig_o [NDUT];
    logic        busy_o [NDUT];
    logic [7:0]  col_o  [NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ws2812_fader_array #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(8), .HOLDOFF_TIME(HOLD),
                         .STEP(1), .LOCK_LED(1'b0)) u_step1 (
        .clk(clk), .rst(rst), .random_i(rnd), .data_request_i(req),
        .trigger_o(trig_o[0]), .color_now_o(col_o[0]), .frame_busy_o(busy_o[0]));

    ws2812_fader_array #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(8), .HOLDOFF_TIME(HOLD),
                         .STEP(16), .LOCK_LED(1'b0)) u_step16 (
        .clk(clk), .rst(rst), .random_i(rnd), .data_request_i(req),
        .trigger_o(trig_o[1]), .color_now_o(col_o[1]), .frame_busy_o(busy_o[1]));

    ws2812_fader_array #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(8), .HOLDOFF_TIME(HOLD),
                         .STEP(1), .LOCK_LED(1'b1)) u_lock (
        .clk(clk), .rst(rst), .random_i(rnd), .data_request_i(req),
        .trigger_o(trig_o[2]), .color_now_o(col_o[2]), .frame_busy_o(busy_o[2]));

    // ---------------- behavioural model ----------------
    int         m_cur [NDUT][FRAME];
    int         m_tgt [NDUT][FRAME];
    logic [7:0] m_color [NDUT];
    logic       m_trig;
    logic       m_busy;
    int         m_idle;
    int         m_pos;

    function automatic int step_of(int d);
        return (d == 1) ? 16 : 1;
    endfunction

    function automatic bit lock_of(int d);
        return d == 2;
    endfunction

    function automatic int toward(int cur, int tgt, int step);
        if (cur < tgt) return cur + (((tgt - cur) < step) ? (tgt - cur) : step);
        if (cur > tgt) return cur - (((cur - tgt) < step) ? (cur - tgt) : step);
        return cur;
    endfunction

    function automatic int rot8(logic [15:0] w, int n);
        logic [15:0] r;
        r = (n == 0) ? w : ((w << n) | (w >> (16 - n)));
        return int'(r[7:0]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_color[d] = 8'h00;
            for (int p = 0; p < FRAME; p++) begin
                m_cur[d][p] = 0;
                m_tgt[d][p] = 0;
            end
        end
        m_trig = 1'b0;
        m_busy = 1'b0;
        m_idle = 0;
        m_pos  = 0;
    endtask

    task automatic model_serve(int p, logic [15:0] w);
        int  base;
        bit  led_ready;
        for (int d = 0; d < NDUT; d++) begin
            m_color[d] = 8'(m_cur[d][p]);
            if (!lock_of(d)) begin
                if (m_cur[d][p] == m_tgt[d][p]) m_tgt[d][p] = int'(w[7:0]);
                else m_cur[d][p] = toward(m_cur[d][p], m_tgt[d][p], step_of(d));
            end else begin
                base      = p - (p % 3);
                led_ready = (p % 3 == 2);
                for (int c = 0; c < 3; c++)
                    if (m_cur[d][base + c] != m_tgt[d][base + c]) led_ready = 1'b0;
                m_cur[d][p] = toward(m_cur[d][p], m_tgt[d][p], step_of(d));
                if (led_ready) begin
                    m_tgt[d][base]     = rot8(w, 0);
                    m_tgt[d][base + 1] = rot8(w, 5);
                    m_tgt[d][base + 2] = rot8(w, 10);
                end
            end
        end
    endtask

    // One clock of the frame protocol as seen from outside.
    task automatic model_edge(logic r, logic [15:0] w);
        if (m_trig) begin
            m_trig = 1'b0;
            m_busy = 1'b1;
            m_pos  = 0;
        end else if (m_busy) begin
            if (r) begin
                model_serve(m_pos, w);
                m_pos++;
                if (m_pos == FRAME) begin
                    m_busy = 1'b0;
                    m_idle = 0;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == HOLD) m_trig = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(logic r, logic [15:0] w);
        req = r;
        rnd = w;
        @(posedge clk);
        model_edge(r, w);
        #1;
    endtask

    task automatic wait_frame(logic [15:0] w);
        for (int i = 0; i < 4 * HOLD + 8 && !m_busy; i++) tick(1'b0, w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0;
        rnd = 16'h1234;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (trig_o[d] !== 1'b0 || busy_o[d] !== 1'b0 || col_o[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset_state dut%0d: got trig=%b busy=%b byte=%02h, expected 0 0 00",
                         d, trig_o[d], busy_o[d], col_o[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= HOLD + 1; k++) begin
            tick(1'b0, 16'h1234);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (trig_o[d] !== (k == HOLD) || busy_o[d] !== (k == HOLD + 1)) begin
                    errors++;
                    $display("FAIL trigger_timing dut%0d clk%0d: got trig=%b busy=%b, expected trig=%b busy=%b",
                             d, k, trig_o[d], busy_o[d], k == HOLD, k == HOLD + 1);
                end
            end
        end
    endtask

    task automatic test_fade();
        int exp_a;
        int exp_b;
        logic [15:0] w;
        do_reset();
        // Up to 0xaa and hold there, then down to 0x55.
        for (int f = 1; f <= 174 + 90; f++) begin
            w = (f <= 174) ? 16'haaaa : 16'h0055;
            wait_frame(w);
            for (int b = 0; b < FRAME; b++) begin
                tick(1'b1, w);
                for (int d = 0; d < NDUT; d++) begin
                    checks++;
                    if (busy_o[d] !== m_busy || col_o[d] !== m_color[d]) begin
                        errors++;
                        $display("FAIL fade_model dut%0d frame%0d byte%0d: got busy=%b byte=%02h, expected busy=%b byte=%02h",
                                 d, f, b, busy_o[d], col_o[d], m_busy, m_color[d]);
                    end
                end
                if (f <= 174) begin
                    exp_a = (f <= 2) ? 0 : (((f - 2) > 170) ? 170 : f - 2);
                    exp_b = (f <= 2) ? 0 : (((f - 2) * 16 > 170) ? 170 : (f - 2) * 16);
                end else begin
                    exp_a = (f == 264) ? 8'h55 : int'(col_o[0]);
                    exp_b = (f == 264) ? 8'h55 : int'(col_o[1]);
                end
                if (f <= 174 || f == 264) begin
                    checks++;
                    if (col_o[0] !== 8'(exp_a) || col_o[1] !== 8'(exp_b)) begin
                        errors++;
                        $display("FAIL fade_ramp frame%0d byte%0d: got step1=%02h step16=%02h, expected %02h %02h",
                                 f, b, col_o[0], col_o[1], exp_a, exp_b);
                    end
                end
            end
        end
    endtask

    task automatic test_holdoff_ignore();
        logic [7:0] snap [NDUT];
        wait_frame(16'h3c3c);
        for (int b = 0; b < FRAME; b++) tick(1'b1, 16'h3c3c);
        for (int d = 0; d < NDUT; d++) snap[d] = m_color[d];
        // Requests through holdoff and the trigger clock are all ignored.
        for (int i = 1; i <= HOLD + 1; i++) begin
            tick(1'b1, 16'($urandom));
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (col_o[d] !== snap[d] || trig_o[d] !== m_trig || busy_o[d] !== m_busy) begin
                    errors++;
                    $display("FAIL holdoff_ignore dut%0d clk%0d: got byte=%02h trig=%b busy=%b, expected byte=%02h trig=%b busy=%b",
                             d, i, col_o[d], trig_o[d], busy_o[d], snap[d], m_trig, m_busy);
                end
            end
        end
        for (int b = 0; b < FRAME; b++) begin
            tick(1'b1, 16'h3c3c);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (col_o[d] !== m_color[d]) begin
                    errors++;
                    $display("FAIL holdoff_after dut%0d byte%0d: got %02h, expected %02h",
                             d, b, col_o[d], m_color[d]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] last [NDUT];
        wait_frame(16'h0f0f);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 16'h0f0f);
            if (i == FRAME) for (int d = 0; d < NDUT; d++) last[d] = m_color[d];
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (busy_o[d] !== (i < FRAME) || trig_o[d] !== (i == FRAME + HOLD)
                    || col_o[d] !== m_color[d]
                    || (i > FRAME && col_o[d] !== last[d])) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d clk%0d: got busy=%b trig=%b byte=%02h, expected busy=%b trig=%b byte=%02h",
                             d, i, busy_o[d], trig_o[d], col_o[d], i < FRAME, i == FRAME + HOLD, m_color[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 3) != 0, 16'($urandom));
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (trig_o[d] !== m_trig || busy_o[d] !== m_busy || col_o[d] !== m_color[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got trig=%b busy=%b byte=%02h, expected trig=%b busy=%b byte=%02h",
                             d, i, trig_o[d], busy_o[d], col_o[d], m_trig, m_busy, m_color[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_frame(16'h5a5a);
        for (int b = 0; b < 3; b++) tick(1'b1, 16'h5a5a);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (trig_o[d] !== 1'b0 || busy_o[d] !== 1'b0 || col_o[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset_async dut%0d: got trig=%b busy=%b byte=%02h, expected 0 0 00",
                         d, trig_o[d], busy_o[d], col_o[d]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= HOLD + 1; k++) begin
            tick(1'b0, 16'h5a5a);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (trig_o[d] !== (k == HOLD) || busy_o[d] !== (k == HOLD + 1)) begin
                    errors++;
                    $display("FAIL reset_restart dut%0d clk%0d: got trig=%b busy=%b, expected trig=%b busy=%b",
                             d, k, trig_o[d], busy_o[d], k == HOLD, k == HOLD + 1);
                end
            end
        end
        for (int b = 0; b < FRAME; b++) begin
            tick(1'b1, 16'h5a5a);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (col_o[d] !== 8'h00 || busy_o[d] !== (b < FRAME - 1)) begin
                    errors++;
                    $display("FAIL reset_frame dut%0d byte%0d: got byte=%02h busy=%b, expected byte=00 busy=%b",
                             d, b, col_o[d], busy_o[d], b < FRAME - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fade();
        test_holdoff_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
